// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - mode encodings and helpers shared by the shift sequencer
package shift_seq_pkg;

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // Callers zero-extend their register into the 32-bit argument.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control and sequence-output bundle of the shift sequencer
interface shift_sequencer_if #(
  parameter int WIDTH     = 5,
  parameter int DIV_WIDTH = 8
);

  logic                 en;
  logic [1:0]           mode;
  logic                 dir;
  logic                 load;
  logic [WIDTH-1:0]     load_value;
  logic [DIV_WIDTH-1:0] div;
  logic [WIDTH-1:0]     q;
  logic                 step;
  logic                 wrap;

  modport master (
    output en, mode, dir, load, load_value, div,
    input  q, step, wrap
  );

  modport slave (
    input  en, mode, dir, load, load_value, div,
    output q, step, wrap
  );

endinterface

// File: rtl/shift_sequencer_tick_prescaler.sv
// rtl/shift_sequencer_tick_prescaler.sv - enabled-cycle prescaler, one tick every div+1 enabled cycles
module tick_prescaler #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 clr,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  // >= lets a div lowered mid-count fire on the very next enabled cycle.
  assign tick = en && (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - ring/Johnson/LFSR sequence register stepped by a prescaled tick
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(5'b10100),
  parameter int               DIV_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);

  logic             tick;
  logic [WIDTH-1:0] q_q,    q_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] nxt;

  tick_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .div  (bus.div),
    .clr  (bus.load),
    .tick (tick)
  );

  // Ring and LFSR recover from states they can never leave on their own.
  always_comb begin
    nxt = q_q;
    case (bus.mode)
      MODE_RING: begin
        if (!is_onehot(32'(q_q))) begin
          nxt = INIT_VALUE;
        end else if (bus.dir) begin
          nxt = {q_q[0], q_q[WIDTH-1:1]};
        end else begin
          nxt = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        end
      end
      MODE_JOHNSON: begin
        if (bus.dir) begin
          nxt = {~q_q[0], q_q[WIDTH-1:1]};
        end else begin
          nxt = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        end
      end
      MODE_LFSR: begin
        if (q_q == '0) begin
          nxt = INIT_VALUE;
        end else begin
          nxt = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
        end
      end
      default: nxt = q_q;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = bus.load_value;
    end else if (tick && (bus.mode != MODE_HOLD)) begin
      q_d    = nxt;
      step_d = 1'b1;
      wrap_d = (nxt == INIT_VALUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT_VALUE;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench for shift_sequencer with a cycle-level reference model
module tb_shift_sequencer;

  localparam int         W    = 5;
  localparam logic [4:0] INIT = 5'b00001;
  localparam logic [4:0] TAPS = 5'b10100;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  shift_sequencer_if #(.WIDTH(W), .DIV_WIDTH(8)) bus ();

  shift_sequencer #(
    .WIDTH      (W),
    .INIT_VALUE (INIT),
    .TAPS       (TAPS),
    .DIV_WIDTH  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next value: rotations taken as windows of {v,v}, feedback as tap parity.
  function automatic logic [4:0] m_next(input logic [4:0] v, input logic [1:0] md, input logic d);
    logic [9:0] dd;
    dd = {v, v};
    case (md)
      2'd0: begin
        if ($countones(v) != 1) return INIT;
        return d ? dd[5:1] : dd[8:4];
      end
      2'd1: return d ? (dd[5:1] ^ 5'b10000) : (dd[8:4] ^ 5'b00001);
      2'd2: begin
        if (v == 5'd0) return INIT;
        return {v[3:0], ($countones(v & TAPS) % 2) == 1};
      end
      default: return v;
    endcase
  endfunction

  logic [4:0] m_q;
  int         m_cnt;
  logic       m_step;
  logic       m_wrap;
  bit         model_on;

  always @(posedge clk) begin
    bit fire;
    if (rst) begin
      m_q = INIT; m_cnt = 0; m_step = 0; m_wrap = 0;
    end else begin
      fire = bus.en && (m_cnt >= int'(bus.div));
      if (bus.load || fire) m_cnt = 0;
      else if (bus.en) m_cnt = m_cnt + 1;
      m_step = 0; m_wrap = 0;
      if (bus.load) begin
        m_q = bus.load_value;
      end else if (fire && bus.mode != 2'd3) begin
        m_q    = m_next(m_q, bus.mode, bus.dir);
        m_step = 1;
        m_wrap = (m_q == INIT);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_q", 32'(bus.q), 32'(m_q));
      chk("model_step", 32'(bus.step), 32'(m_step));
      chk("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] ring_l [5];
    logic [4:0] ring_r [5];
    logic [4:0] john   [10];
    logic [4:0] lfsr_first [3];
    bit         en_pat   [11];
    bit         step_pat [11];
    bit         seen [32];
    int         distinct;

    ring_l     = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    ring_r     = '{5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
    john       = '{5'h03, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h10, 5'h00, 5'h01};
    lfsr_first = '{5'h02, 5'h04, 5'h09};
    en_pat     = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    step_pat   = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};

    checks = 0; errors = 0; model_on = 0;
    rst = 1; bus.en = 1; bus.mode = 2'd0; bus.dir = 0;
    bus.load = 0; bus.load_value = '0; bus.div = 8'd0;

    cyc();
    model_on = 1;
    chk("reset_q", 32'(bus.q), 32'h01);
    chk("reset_step", 32'(bus.step), 0);
    chk("reset_wrap", 32'(bus.wrap), 0);
    rst = 0;

    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ring_l_q", 32'(bus.q), 32'(ring_l[i]));
      chk("ring_l_step", 32'(bus.step), 1);
      chk("ring_l_wrap", 32'(bus.wrap), 32'(i == 4));
    end

    bus.dir = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("ring_r_q", 32'(bus.q), 32'(ring_r[i]));
      chk("ring_r_wrap", 32'(bus.wrap), 32'(i == 4));
    end

    bus.dir = 0; bus.div = 8'd2;
    for (int i = 0; i < 11; i++) begin
      bus.en = en_pat[i];
      cyc();
      chk("presc_step", 32'(bus.step), 32'(step_pat[i]));
    end
    bus.en = 1;
    chk("presc_q", 32'(bus.q), 32'h08);

    bus.div = 8'd0; bus.mode = 2'd1; bus.load = 1; bus.load_value = 5'h01;
    cyc();
    bus.load = 0;
    chk("john_load_q", 32'(bus.q), 32'h01);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("john_q", 32'(bus.q), 32'(john[i]));
      chk("john_wrap", 32'(bus.wrap), 32'(i == 9));
    end

    bus.mode = 2'd2;
    foreach (seen[k]) seen[k] = 0;
    distinct = 0;
    for (int i = 0; i < 31; i++) begin
      cyc();
      if (i < 3) chk("lfsr_first", 32'(bus.q), 32'(lfsr_first[i]));
      chk("lfsr_wrap", 32'(bus.wrap), 32'(i == 30));
      if (!seen[bus.q]) distinct++;
      seen[bus.q] = 1;
    end
    chk("lfsr_distinct", distinct, 31);
    chk("lfsr_end_q", 32'(bus.q), 32'h01);

    bus.load = 1; bus.load_value = 5'h00;
    cyc();
    bus.load = 0;
    chk("lfsr_zero_q", 32'(bus.q), 32'h00);
    cyc();
    chk("lfsr_lock_q", 32'(bus.q), 32'h01);
    chk("lfsr_lock_wrap", 32'(bus.wrap), 1);

    bus.mode = 2'd0; bus.load = 1; bus.load_value = 5'b00110;
    cyc();
    bus.load = 0;
    chk("ring_bad_load_q", 32'(bus.q), 32'h06);
    cyc();
    chk("ring_fix_q", 32'(bus.q), 32'h01);
    chk("ring_fix_step", 32'(bus.step), 1);
    chk("ring_fix_wrap", 32'(bus.wrap), 1);

    bus.load = 1; bus.load_value = 5'b01010;
    cyc();
    bus.load = 0;
    chk("load_tick_q", 32'(bus.q), 32'h0A);
    chk("load_tick_step", 32'(bus.step), 0);

    bus.div = 8'd3;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid_q", 32'(bus.q), 32'h01);
    chk("rst_mid_step", 32'(bus.step), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rst_mid_delay", 32'(bus.step), 32'(k == 3));
    end
    chk("rst_mid_after_q", 32'(bus.q), 32'h02);

    bus.mode = 2'd3;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("hold_q", 32'(bus.q), 32'h02);
      chk("hold_step", 32'(bus.step), 0);
    end

    bus.mode = 2'd0; bus.div = 8'd6;
    cyc();
    bus.div = 8'd1;
    cyc();
    chk("div_lower_step", 32'(bus.step), 1);

    model_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
